// File: rtl/timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and reset constants for the
// timer_counter peripheral and its prescaler.
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CMP    = 2'd1;
    localparam logic [1:0] ADDR_CNT    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN           = 0;
    localparam int CTRL_CLR_ON_MATCH = 1;
    localparam int CTRL_MATCH_IE     = 2;
    localparam int CTRL_OVF_IE       = 3;
    localparam int CTRL_PS_LSB       = 4;
    localparam int CTRL_PS_MSB       = 6;

    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;

    // Bit 7 of CTRL is reserved: never stored, always reads back as 0.
    localparam logic [7:0] CTRL_WMASK = 8'h7F;

    localparam logic [7:0] CTRL_RST   = 8'h00;
    localparam logic [7:0] CMP_RST    = 8'hFF;
    localparam logic [7:0] CNT_RST    = 8'h00;
    localparam logic [1:0] STATUS_RST = 2'b00;
    localparam logic [7:0] DOUT_RST   = 8'h00;

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two clock divider: one-cycle tick every 2^p cycles while enabled;
// count restarts on 'restart' and is held at zero while disabled.
module timer_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       restart,
    input  logic [2:0] p,
    output logic       tick
);

    logic [6:0] cnt_q, cnt_d;
    logic [6:0] limit;

    always_comb begin
        limit = 7'h7F >> (3'd7 - p);
        tick  = enable && (cnt_q == limit);
        cnt_d = cnt_q + 7'd1;
        if (restart || !enable || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// 8-bit memory-mapped timer/counter with compare match, overflow, W1C status
// and level IRQ. Optional registered PWM output is built when TIMER_PWM_EN is defined.
module timer_counter
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel,
    input  logic [1:0] addr,
    input  logic [7:0] dIn,
    input  logic       writeEn,
    input  logic       readEn,
    output logic [7:0] dOut,
    output logic       irq,
    output logic       pwmOut
);

    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] cmp_q, cmp_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] status_q, status_d;
    logic [7:0] dout_q, dout_d;
    logic       rdy_q;
    logic [1:0] status_set, status_clr;
    logic [7:0] rd_data;
    logic       wr, rd, wr_ctrl, wr_cmp, wr_cnt, wr_status;
    logic       tick, match;

    assign wr        = sel && writeEn;
    // rdy_q blocks a read strobe on the first edge after reset release.
    assign rd        = sel && readEn && rdy_q;
    assign wr_ctrl   = wr && (addr == ADDR_CTRL);
    assign wr_cmp    = wr && (addr == ADDR_CMP);
    assign wr_cnt    = wr && (addr == ADDR_CNT);
    assign wr_status = wr && (addr == ADDR_STATUS);

    timer_prescaler u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (ctrl_q[CTRL_EN]),
        .restart (wr_ctrl),
        .p       (ctrl_q[CTRL_PS_MSB:CTRL_PS_LSB]),
        .tick    (tick)
    );

    always_comb begin
        match      = (cnt_q == cmp_q);
        status_set = 2'b00;
        cnt_d      = cnt_q;
        ctrl_d     = wr_ctrl ? (dIn & CTRL_WMASK) : ctrl_q;
        cmp_d      = wr_cmp ? dIn : cmp_q;

        // A CPU write to CNT swallows any tick in the same cycle.
        if (wr_cnt) begin
            cnt_d = dIn;
        end else if (tick) begin
            if (ctrl_q[CTRL_CLR_ON_MATCH] && match) begin
                cnt_d                  = 8'h00;
                status_set[STAT_MATCH] = 1'b1;
            end else begin
                cnt_d                  = cnt_q + 8'd1;
                status_set[STAT_MATCH] = match;
                status_set[STAT_OVF]   = (cnt_q == 8'hFF);
            end
        end

        status_clr = wr_status ? dIn[1:0] : 2'b00;
        status_d   = (status_q & ~status_clr) | status_set;

        case (addr)
            ADDR_CTRL: rd_data = ctrl_q;
            ADDR_CMP:  rd_data = cmp_q;
            ADDR_CNT:  rd_data = cnt_q;
            default:   rd_data = {6'b0, status_q};
        endcase
        dout_d = rd ? rd_data : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= CTRL_RST;
            cmp_q    <= CMP_RST;
            cnt_q    <= CNT_RST;
            status_q <= STATUS_RST;
            dout_q   <= DOUT_RST;
            rdy_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            cmp_q    <= cmp_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            dout_q   <= dout_d;
            rdy_q    <= 1'b1;
        end
    end

    assign dOut = dout_q;
    assign irq  = (status_q[STAT_MATCH] & ctrl_q[CTRL_MATCH_IE])
                | (status_q[STAT_OVF]   & ctrl_q[CTRL_OVF_IE]);

`ifdef TIMER_PWM_EN
    logic pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= ctrl_q[CTRL_EN] && (cnt_q < cmp_q);
        end
    end

    assign pwmOut = pwm_q;
`else
    assign pwmOut = 1'b0;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register-access vector table followed by
// hand-written multi-cycle counter, IRQ, prescaler, priority, PWM and reset sequences.
module tb_timer_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic [1:0] addr;
    logic [7:0] dIn;
    logic       writeEn;
    logic       readEn;
    logic [7:0] dOut;
    logic       irq;
    logic       pwmOut;

    int checks = 0;
    int errors = 0;

    timer_counter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .addr    (addr),
        .dIn     (dIn),
        .writeEn (writeEn),
        .readEn  (readEn),
        .dOut    (dOut),
        .irq     (irq),
        .pwmOut  (pwmOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       w;
        logic       r;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp_dout;
        logic       exp_irq;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic s, input logic w, input logic r,
                                input logic [1:0] a, input logic [7:0] d,
                                input logic [7:0] e, input logic i);
        vec_t v;
        v.s = s; v.w = w; v.r = r; v.a = a; v.d = d;
        v.exp_dout = e; v.exp_irq = i;
        return v;
    endfunction

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, let the rising edge take it, sample 1 ns later.
    task automatic op(input logic s, input logic w, input logic r,
                      input logic [1:0] a, input logic [7:0] d);
        sel = s; writeEn = w; readEn = r; addr = a; dIn = d;
        @(posedge clk);
        #1;
        sel = 1'b0; writeEn = 1'b0; readEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        op(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic rdchk(input string nm, input logic [1:0] a, input logic [7:0] exp);
        op(1'b1, 1'b0, 1'b1, a, 8'h00);
        chk8(nm, dOut, exp);
    endtask

    initial begin
        int highs;
        rst_n = 1'b0; sel = 1'b0; addr = 2'd0; dIn = 8'h00; writeEn = 1'b0; readEn = 1'b0;

        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 8'h00, 8'hFF, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 2'd1, 8'h5A, 8'hFF, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 8'h00, 8'h5A, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 2'd1, 8'h11, 8'h5A, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 8'h5A, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 8'h00, 8'h5A, 1'b0);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 2'd1, 8'h33, 8'h5A, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 2'd1, 8'h00, 8'h33, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 2'd0, 8'hF6, 8'h33, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 8'h76, 1'b0);
        tbl[13] = mk(1'b1, 1'b1, 1'b0, 2'd2, 8'h21, 8'h76, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 1'b1, 2'd2, 8'h00, 8'h21, 1'b0);
        tbl[15] = mk(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 8'h21, 1'b0);
        tbl[16] = mk(1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        tbl[17] = mk(1'b1, 1'b1, 1'b0, 2'd3, 8'h03, 8'h00, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk8("reset_dout", dOut, 8'h00);
        chk8("reset_irq", {7'b0, irq}, 8'h00);
        chk8("reset_pwm", {7'b0, pwmOut}, 8'h00);

        // Read strobe on the first edge after release must be ignored.
        rst_n = 1'b1;
        op(1'b1, 1'b0, 1'b1, 2'd1, 8'h00);
        chk8("first_edge_no_read", dOut, 8'h00);

        for (int i = 0; i < 19; i++) begin
            op(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
            chk8($sformatf("vec%0d_dout", i), dOut, tbl[i].exp_dout);
            chk8($sformatf("vec%0d_irq", i), {7'b0, irq}, {7'b0, tbl[i].exp_irq});
        end

        // Clear-on-match wrap at CMP=3.
        wr(2'd1, 8'h03);
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h03);
        for (int i = 0; i < 5; i++) begin
            rdchk($sformatf("com_cnt%0d", i), 2'd2, (i == 4) ? 8'h00 : 8'(i));
            chk8("com_irq", {7'b0, irq}, 8'h00);
        end
        rdchk("com_status", 2'd3, 8'h01);
        chk8("com_irq_after", {7'b0, irq}, 8'h00);
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h03);
        rdchk("w1c_status", 2'd3, 8'h00);

        // Overflow wrap and W1C clear of the interrupt.
        wr(2'd1, 8'h80);
        wr(2'd2, 8'hFE);
        wr(2'd0, 8'h09);
        idle();
        chk8("ovf_irq_pre", {7'b0, irq}, 8'h00);
        idle();
        chk8("ovf_irq", {7'b0, irq}, 8'h01);
        rdchk("ovf_status", 2'd3, 8'h02);
        chk8("ovf_irq_hold", {7'b0, irq}, 8'h01);
        wr(2'd3, 8'h02);
        chk8("ovf_irq_clr", {7'b0, irq}, 8'h00);
        wr(2'd0, 8'h00);
        rdchk("ovf_cnt_after", 2'd2, 8'h03);
        wr(2'd3, 8'h03);

        // Clear-on-match reload from 0xFF is a match, not an overflow.
        wr(2'd1, 8'hFF);
        wr(2'd2, 8'hFF);
        wr(2'd0, 8'h0B);
        idle();
        chk8("reload_irq", {7'b0, irq}, 8'h00);
        wr(2'd0, 8'h00);
        rdchk("reload_status", 2'd3, 8'h01);
        rdchk("reload_cnt", 2'd2, 8'h01);
        wr(2'd3, 8'h03);

        // Prescale p=3 and restart on CTRL rewrite.
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h31);
        for (int i = 0; i < 8; i++) rdchk($sformatf("ps_a%0d", i), 2'd2, 8'h00);
        rdchk("ps_a_tick", 2'd2, 8'h01);
        rdchk("ps_b0", 2'd2, 8'h01);
        rdchk("ps_b1", 2'd2, 8'h01);
        wr(2'd0, 8'h31);
        for (int i = 0; i < 8; i++) rdchk($sformatf("ps_c%0d", i), 2'd2, 8'h01);
        rdchk("ps_c_tick", 2'd2, 8'h02);
        wr(2'd0, 8'h00);

        // CNT write wins over a same-cycle tick.
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h01);
        idle();
        wr(2'd2, 8'h40);
        rdchk("prio_cnt", 2'd2, 8'h40);
        wr(2'd0, 8'h00);
        rdchk("prio_cnt_stop", 2'd2, 8'h42);
        wr(2'd3, 8'h03);

        // PWM duty over one full 256-tick period.
        wr(2'd1, 8'h80);
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h01);
        repeat (4) idle();
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            idle();
            if (pwmOut === 1'b1) highs++;
        end
`ifdef TIMER_PWM_EN
        chkint("pwm_high_count", highs, 128);
`else
        chkint("pwm_high_count", highs, 0);
`endif
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h03);

        // Asynchronous reset mid-count with both status bits set.
        wr(2'd1, 8'hFE);
        wr(2'd2, 8'hFE);
        wr(2'd0, 8'h0D);
        idle();
        idle();
        chk8("arst_irq_pre", {7'b0, irq}, 8'h01);
        rdchk("arst_status_pre", 2'd3, 8'h03);
        #3;
        rst_n = 1'b0;
        #1;
        chk8("arst_dout", dOut, 8'h00);
        chk8("arst_irq", {7'b0, irq}, 8'h00);
        chk8("arst_pwm", {7'b0, pwmOut}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        rdchk("arst_ctrl", 2'd0, 8'h00);
        rdchk("arst_cmp", 2'd1, 8'hFF);
        rdchk("arst_cnt", 2'd2, 8'h00);
        rdchk("arst_status", 2'd3, 8'h00);
        chk8("arst_irq_post", {7'b0, irq}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-003 SHALL have port sel  input  1  chip select from the I/O address decode of dMemIOAddress.
REQ-004 SHALL have port addr  input  2  register offset (dMemIOAddress[1:0]).
REQ-005 SHALL have port dIn  input  8  write data (CPU dMemIOIn).
REQ-006 SHALL have port writeEn  input  1  write strobe (CPU dMemIOWriteEn).
REQ-007 SHALL have port readEn  input  1  read strobe (CPU dMemIOReadEn).
REQ-008 SHALL have port dOut  output  8  registered read data to the CPU data-return mux.
REQ-009 SHALL have port irq  output  1  level interrupt to CPU interrupt_0/1/2.
REQ-010 SHALL have port pwmOut  output  1  PWM waveform (see Configuration).

Function
REQ-011 SHALL map registers: 0 CTRL, 1 CMP, 2 CNT, 3 STATUS.
REQ-012 SHALL define CTRL bits: [0] enable, [1] clear-on-match, [2] match IE, [3] overflow IE, [6:4] prescale select p, [7] reserved, reads 0.
REQ-013 SHALL generate a tick every 2^p clk cycles while enable=1; p=0 gives a tick every cycle.
REQ-014 SHALL reset the prescaler count to 0 on any CTRL write and hold it at 0 while enable=0.
REQ-015 SHALL, on a tick with clear-on-match=1 and CNT==CMP, load CNT with 0 and set STATUS[0] (match).
REQ-016 SHALL, on any other tick, increment CNT modulo 256, and set STATUS[0] if CNT==CMP before the increment.
REQ-017 SHALL set STATUS[1] (overflow) on a tick that wraps CNT from 0xFF to 0x00 by increment; a clear-on-match reload is not overflow.
REQ-018 SHALL give a CPU write to CNT priority over a same-cycle tick; that tick is discarded.
REQ-019 SHALL clear STATUS bits written with 1 (W1C); a same-cycle set wins over the clear.
REQ-020 SHALL drive irq = (STATUS[0]&CTRL[2]) | (STATUS[1]&CTRL[3]), combinationally from registered state.
REQ-021 SHALL register dOut one cycle after sel&readEn with the addressed register's pre-edge value, and hold dOut otherwise.
REQ-022 SHALL ignore writeEn/readEn when sel=0; simultaneous read and write to one register returns the old value.

Reset
REQ-023 SHALL, while rst_n=0, force CTRL=0x00, CMP=0xFF, CNT=0x00, STATUS=0x00, prescaler=0, dOut=0x00, irq=0, pwmOut=0.
REQ-024 SHALL abandon a prescale period or pending read on reset mid-operation; no tick or dOut update on the first edge after release.

Configuration
REQ-025 SHALL compile PWM logic only when TIMER_PWM_EN is defined: pwmOut registered, =1 while enable=1 and CNT<CMP, else 0.
REQ-026 SHALL, without TIMER_PWM_EN, keep port pwmOut tied to constant 0 with no PWM logic.

Structure
REQ-027 SHALL place register offsets, CTRL/STATUS bit positions and reset constants in shared package timer_pkg.
REQ-028 SHALL implement the divider as sub-module timer_prescaler (inputs clk, rst_n, enable, restart, p; output tick).

Verification
REQ-029 SHALL cover: CMP=3, CTRL=0x03 -> CNT 0,1,2,3,0 on consecutive cycles; STATUS[0]=1 after the 4th tick; irq stays 0.
REQ-030 SHALL cover: CTRL=0x09, CNT=0xFE -> after 2 ticks CNT=0x00, STATUS=0x02, irq=1; writing STATUS=0x02 -> irq=0 next cycle.
REQ-031 SHALL cover: CTRL=0x31 (p=3) -> CNT increments every 8 cycles; CTRL rewritten mid-period restarts the 8-cycle count.
REQ-032 SHALL cover: CNT write of 0x40 in the same cycle as a tick -> CNT=0x40; read of addr 2 -> dOut=0x40 one cycle after readEn.
REQ-033 SHALL cover: rst_n low mid-count with STATUS=0x03 -> all registers and outputs at reset values immediately, asynchronously.
REQ-034 SHALL cover, with TIMER_PWM_EN: CMP=0x80, p=0, CTRL=0x01 -> pwmOut high for 128 and low for 128 of each 256 ticks.
